cmd_rx: RTL and testbench

Command-stream receiver: consumes the framed byte stream on the link toward the device (START, OP, SZ, A0..A3, CRC, optional write payload), validates the CRC, and issues one memory request per good frame. For write requests it forwards exactly the payload byte count to the request handler. It is the device-side counterpart of the command transmitter and feeds the memory request fabric.

---
 rtl/cmd_rx_if.sv | 31 +++
 rtl/cmd_rx.sv | 189 ++++++++++++++++++
 tb/tb_cmd_rx.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_rx_if.sv
// cmd_rx_if: command stream, memory request and payload signals of the command receiver.
// The slave modport is the receiver side; the master modport drives it.
interface cmd_rx_if;
    logic [7:0]  i_st_data;
    logic        i_st_valid;
    logic        o_st_ready;
    logic        o_mreq_valid;
    logic        i_mreq_ready;
    logic        o_mreq_wr;
    logic [1:0]  o_mreq_wsize;
    logic        o_mreq_aincr;
    logic [7:0]  o_mreq_size;
    logic [31:0] o_mreq_addr;
    logic [7:0]  o_rx_data;
    logic        o_rx_data_valid;
    logic        i_rx_data_ready;
    logic        o_crc_err;
    logic        o_timeout;

    modport slave (
        input  i_st_data, i_st_valid, i_mreq_ready, i_rx_data_ready,
        output o_st_ready, o_mreq_valid, o_mreq_wr, o_mreq_wsize, o_mreq_aincr,
               o_mreq_size, o_mreq_addr, o_rx_data, o_rx_data_valid, o_crc_err, o_timeout
    );

    modport master (
        output i_st_data, i_st_valid, i_mreq_ready, i_rx_data_ready,
        input  o_st_ready, o_mreq_valid, o_mreq_wr, o_mreq_wsize, o_mreq_aincr,
               o_mreq_size, o_mreq_addr, o_rx_data, o_rx_data_valid, o_crc_err, o_timeout
    );
endinterface

// File: rtl/cmd_rx.sv
// cmd_rx: framed command-stream receiver. Parses START, OP, SZ, A0..A3, CRC, checks the
// CRC-8 (poly 0x07, init 0x00) over START..A3, issues one memory request per good frame
// and passes exactly the write payload byte count through to the request handler.
// Optional header inter-byte timeout: define CMD_RX_TIMEOUT_EN.
module cmd_rx #(
    parameter logic [7:0]  START_BYTE     = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic     i_clk,
    input logic     i_rst,
    cmd_rx_if.slave io_bus
);

    typedef enum logic [1:0] {ST_HUNT, ST_HEADER, ST_EXEC} state_t;

    localparam logic [2:0] HDR_CRC_IDX = 3'd6;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_idx;
    logic [7:0]  r_crc, r_op, r_sz;
    logic [31:0] r_addr;
    logic        r_mreq_valid, r_mreq_wr, r_mreq_aincr;
    logic [1:0]  r_mreq_wsize;
    logic [7:0]  r_mreq_size;
    logic [31:0] r_mreq_addr;
    logic [11:0] r_cnt, w_cnt_nxt, w_pay_len, w_words;
    logic        r_crc_err;
    logic        w_st_ready, w_accept, w_crc_ok, w_pay_acc, w_hs, w_tmo_hit;
    logic        w_rx_valid;
    logic [7:0]  w_rx_data;

    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] x;
        x = c ^ d;
        for (int i = 0; i < 8; i++) begin
            x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
        end
        return x;
    endfunction

    assign w_accept  = io_bus.i_st_valid && w_st_ready;
    assign w_crc_ok  = (io_bus.i_st_data == r_crc);
    assign w_hs      = r_mreq_valid && io_bus.i_mreq_ready;
    assign w_words   = {4'd0, r_sz} + 12'd1;
    assign w_pay_len = r_op[0] ? (w_words << r_op[5:4]) : 12'd0;
    assign w_pay_acc = (r_state == ST_EXEC) && (r_cnt != 12'd0) &&
                       io_bus.i_st_valid && io_bus.i_rx_data_ready;
    assign w_cnt_nxt = r_cnt - {11'd0, w_pay_acc};

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_HUNT;
        else       r_state <= w_state_nxt;
    end

    // Next state, input ready and combinational payload passthrough
    always_comb begin
        w_state_nxt = r_state;
        w_st_ready  = 1'b1;
        w_rx_valid  = 1'b0;
        w_rx_data   = 8'h00;
        case (r_state)
            ST_HUNT: begin
                if (io_bus.i_st_valid && io_bus.i_st_data == START_BYTE) w_state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                if (io_bus.i_st_valid && r_idx == HDR_CRC_IDX) begin
                    w_state_nxt = w_crc_ok ? ST_EXEC : ST_HUNT;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_EXEC: begin
                if (r_cnt != 12'd0) begin
                    w_st_ready = io_bus.i_rx_data_ready;
                    w_rx_valid = io_bus.i_st_valid;
                    w_rx_data  = io_bus.i_st_data;
                end else begin
                    w_st_ready = 1'b0;
                end
                // Leave once the request is (or just got) accepted and the payload is drained
                if ((!r_mreq_valid || w_hs) && w_cnt_nxt == 12'd0) w_state_nxt = ST_HUNT;
            end
            default: w_state_nxt = ST_HUNT;
        endcase
    end

    // Header capture, CRC accumulation, request latching and payload counting
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx        <= 3'd0;
            r_crc        <= 8'h00;
            r_op         <= 8'h00;
            r_sz         <= 8'h00;
            r_addr       <= 32'h0;
            r_mreq_valid <= 1'b0;
            r_mreq_wr    <= 1'b0;
            r_mreq_wsize <= 2'd0;
            r_mreq_aincr <= 1'b0;
            r_mreq_size  <= 8'h00;
            r_mreq_addr  <= 32'h0;
            r_cnt        <= 12'd0;
            r_crc_err    <= 1'b0;
        end else begin
            r_crc_err <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_accept && io_bus.i_st_data == START_BYTE) begin
                        r_crc <= crc8(8'h00, io_bus.i_st_data);
                        r_idx <= 3'd0;
                    end
                end
                ST_HEADER: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 3'd1;
                        r_crc <= crc8(r_crc, io_bus.i_st_data);
                        case (r_idx)
                            3'd0: r_op          <= io_bus.i_st_data;
                            3'd1: r_sz          <= io_bus.i_st_data;
                            3'd2: r_addr[7:0]   <= io_bus.i_st_data;
                            3'd3: r_addr[15:8]  <= io_bus.i_st_data;
                            3'd4: r_addr[23:16] <= io_bus.i_st_data;
                            3'd5: r_addr[31:24] <= io_bus.i_st_data;
                            3'd6: begin
                                if (w_crc_ok) begin
                                    r_mreq_valid <= 1'b1;
                                    r_mreq_wr    <= r_op[0];
                                    r_mreq_aincr <= r_op[3];
                                    r_mreq_wsize <= r_op[5:4];
                                    r_mreq_size  <= r_sz;
                                    r_mreq_addr  <= r_addr;
                                    r_cnt        <= w_pay_len;
                                end else begin
                                    r_crc_err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    if (w_hs) r_mreq_valid <= 1'b0;
                    r_cnt <= w_cnt_nxt;
                end
                default: ;
            endcase
        end
    end

`ifdef CMD_RX_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_tmo;
    logic          r_timeout;

    // Header is always ready, so an idle cycle is simply one without valid
    assign w_tmo_hit = (r_state == ST_HEADER) && !io_bus.i_st_valid &&
                       (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter for the header phase
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tmo     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tmo_hit;
            if (r_state != ST_HEADER || io_bus.i_st_valid || w_tmo_hit) r_tmo <= '0;
            else                                                        r_tmo <= r_tmo + TW'(1);
        end
    end

    assign io_bus.o_timeout = r_timeout;
`else
    assign w_tmo_hit        = 1'b0;
    assign io_bus.o_timeout = 1'b0;
`endif

    assign io_bus.o_st_ready      = w_st_ready;
    assign io_bus.o_rx_data       = w_rx_data;
    assign io_bus.o_rx_data_valid = w_rx_valid;
    assign io_bus.o_mreq_valid    = r_mreq_valid;
    assign io_bus.o_mreq_wr       = r_mreq_wr;
    assign io_bus.o_mreq_wsize    = r_mreq_wsize;
    assign io_bus.o_mreq_aincr    = r_mreq_aincr;
    assign io_bus.o_mreq_size     = r_mreq_size;
    assign io_bus.o_mreq_addr     = r_mreq_addr;
    assign io_bus.o_crc_err       = r_crc_err;

endmodule

// File: tb/tb_cmd_rx.sv
// tb_cmd_rx: self-checking bench for cmd_rx with a frame/request/payload reference model.
module tb_cmd_rx;
    logic clk = 1'b0;
    logic rst;

    cmd_rx_if bus ();

    cmd_rx #(
        .START_BYTE     (8'hA5),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_crc  = 0;
    int n_tmo  = 0;
    bit bp_en  = 1'b0;

    logic [43:0] got_req[$];
    logic [7:0]  got_pay[$];
    logic [7:0]  exp_pay[$];
    logic [7:0]  frm[$];
    logic [43:0] w_pack;
    logic [43:0] prev_pack;
    bit          prev_pend = 1'b0;

    assign w_pack = {bus.o_mreq_wr, bus.o_mreq_wsize, bus.o_mreq_aincr, bus.o_mreq_size,
                     bus.o_mreq_addr};

    // Reference model: CRC-8 (x^8+x^2+x+1) as long division over the message bits
    function automatic logic [7:0] crc_model(input logic [7:0] m[$]);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        foreach (m[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = r[7] ^ m[i][b];
                r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return r;
    endfunction

    function automatic void make_frame(input logic [7:0] op, input logic [7:0] sz,
                                       input logic [31:0] addr, input logic [7:0] flip);
        frm = '{8'hA5, op, sz, addr[7:0], addr[15:8], addr[23:16], addr[31:24]};
        frm.push_back(crc_model(frm) ^ flip);
    endfunction

    function automatic int pay_len(input logic [7:0] op, input logic [7:0] sz);
        return op[0] ? ((int'(sz) + 1) << op[5:4]) : 0;
    endfunction

    function automatic logic [43:0] exp_req(input logic [7:0] op, input logic [7:0] sz,
                                            input logic [31:0] addr);
        return {op[0], op[5:4], op[3], sz, addr};
    endfunction

    // Observer: records accepted requests, delivered payload, pulses; checks field stability
    always @(negedge clk) begin
        if (rst) begin
            prev_pend = 1'b0;
        end else begin
            if (bus.o_rx_data_valid && bus.i_rx_data_ready) got_pay.push_back(bus.o_rx_data);
            if (bus.o_mreq_valid && bus.i_mreq_ready) got_req.push_back(w_pack);
            if (bus.o_crc_err) n_crc++;
            if (bus.o_timeout) n_tmo++;
            if (prev_pend && bus.o_mreq_valid) begin
                checks++;
                if (w_pack !== prev_pack) begin
                    errors++;
                    $display("FAIL mreq_stable got %h want %h", w_pack, prev_pack);
                end
            end
            prev_pend = bus.o_mreq_valid && !bus.i_mreq_ready;
            prev_pack = w_pack;
        end
    end

    task automatic send_byte(input logic [7:0] b, output int waited);
        bus.i_st_data  = b;
        bus.i_st_valid = 1'b1;
        waited = 0;
        forever begin
            if (bp_en) begin
                bus.i_rx_data_ready = 1'($urandom_range(0, 1));
                bus.i_mreq_ready    = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (bus.o_st_ready) break;
            waited++;
            if (waited > 300) begin
                checks++;
                errors++;
                $display("FAIL send_bound byte %h not accepted within 300 cycles", b);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.i_st_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.i_st_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic finish_req();
        int k;
        bus.i_mreq_ready    = 1'b1;
        bus.i_rx_data_ready = 1'b1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.o_st_ready && !bus.o_mreq_valid) break;
            @(posedge clk); #1;
        end
        if (k == 50) begin
            checks++;
            errors++;
            $display("FAIL finish_bound request not retired within 50 cycles");
        end
        @(posedge clk); #1;
        bus.i_mreq_ready = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] op, input logic [7:0] sz, input logic [31:0] addr,
                            input logic [7:0] flip);
        int w;
        logic [7:0] b;
        got_req.delete();
        got_pay.delete();
        exp_pay.delete();
        make_frame(op, sz, addr, flip);
        foreach (frm[i]) begin
            if (bp_en && $urandom_range(0, 3) == 0) idle(1);
            send_byte(frm[i], w);
        end
        if (flip != 8'h00) begin
            idle(1);
        end else begin
            for (int i = 0; i < pay_len(op, sz); i++) begin
                if (bp_en && $urandom_range(0, 3) == 0) idle(1);
                b = 8'($urandom);
                exp_pay.push_back(b);
                send_byte(b, w);
            end
            finish_req();
        end
        bus.i_rx_data_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (bus.o_st_ready !== 1'b1) begin errors++;
            $display("FAIL reset_st_ready got %b want 1", bus.o_st_ready); end
        checks++; if (bus.o_mreq_valid !== 1'b0) begin errors++;
            $display("FAIL reset_mreq_valid got %b want 0", bus.o_mreq_valid); end
        checks++; if (w_pack !== 44'h0) begin errors++;
            $display("FAIL reset_mreq_fields got %h want 0", w_pack); end
        checks++; if (bus.o_rx_data_valid !== 1'b0 || bus.o_rx_data !== 8'h00) begin errors++;
            $display("FAIL reset_rx got %b/%h want 0/00", bus.o_rx_data_valid, bus.o_rx_data); end
        checks++; if (bus.o_crc_err !== 1'b0 || bus.o_timeout !== 1'b0) begin errors++;
            $display("FAIL reset_pulses got %b%b want 00", bus.o_crc_err, bus.o_timeout); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_read();
        int w;
        logic [43:0] e;
        e = exp_req(8'h00, 8'h03, 32'h76543210);
        got_req.delete();
        got_pay.delete();
        bus.i_mreq_ready = 1'b0;
        make_frame(8'h00, 8'h03, 32'h76543210, 8'h00);
        foreach (frm[i]) send_byte(frm[i], w);
        @(negedge clk);
        checks++; if (bus.o_mreq_valid !== 1'b1) begin errors++;
            $display("FAIL read_latency mreq_valid got %b want 1", bus.o_mreq_valid); end
        checks++; if (w_pack !== e) begin errors++;
            $display("FAIL read_fields got %h want %h", w_pack, e); end
        checks++; if (bus.o_rx_data_valid !== 1'b0 || bus.o_st_ready !== 1'b0) begin errors++;
            $display("FAIL read_no_payload got rxv=%b rdy=%b want 0 0",
                     bus.o_rx_data_valid, bus.o_st_ready); end
        @(posedge clk); #1;
        bus.i_mreq_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_mreq_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.o_st_ready !== 1'b1 || bus.o_mreq_valid !== 1'b0) begin errors++;
            $display("FAIL read_exit got rdy=%b valid=%b want 1 0",
                     bus.o_st_ready, bus.o_mreq_valid); end
        checks++; if (w_pack !== e) begin errors++;
            $display("FAIL read_hold got %h want %h", w_pack, e); end
        checks++; if (got_req.size() != 1 || got_pay.size() != 0) begin errors++;
            $display("FAIL read_counts got req=%0d pay=%0d want 1 0", got_req.size(),
                     got_pay.size()); end
        @(posedge clk); #1;
    endtask

    task automatic test_write(input bit hs_first);
        int w;
        int bad;
        logic [7:0]  b;
        logic [7:0]  pay[$];
        logic [43:0] e0, e1;
        e0 = exp_req(8'h11, 8'h01, 32'hCAFE0000 | 32'(hs_first));
        e1 = exp_req(8'h08, 8'h00, 32'h00001000);
        got_req.delete();
        got_pay.delete();
        bus.i_mreq_ready    = hs_first;
        bus.i_rx_data_ready = 1'b1;
        make_frame(8'h11, 8'h01, 32'hCAFE0000 | 32'(hs_first), 8'h00);
        foreach (frm[i]) send_byte(frm[i], w);
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            pay.push_back(b);
            send_byte(b, w);
        end
        if (!hs_first) begin
            bus.i_st_data  = 8'hA5;
            bus.i_st_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checks++; if (bus.o_st_ready !== 1'b0 || bus.o_rx_data_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL write_holdoff got rdy=%b rxv=%b want 0 0",
                             bus.o_st_ready, bus.o_rx_data_valid); end
                @(posedge clk); #1;
            end
            bus.i_mreq_ready = 1'b1;
            @(negedge clk);
            checks++; if (bus.o_st_ready !== 1'b0) begin errors++;
                $display("FAIL write_hs_cycle got rdy=%b want 0", bus.o_st_ready); end
            @(posedge clk); #1;
            bus.i_mreq_ready = 1'b0;
        end
        send_byte(8'hA5, w);
        checks++; if (w != 0) begin errors++;
            $display("FAIL b2b_start waited %0d want 0", w); end
        make_frame(8'h08, 8'h00, 32'h00001000, 8'h00);
        for (int i = 1; i < frm.size(); i++) send_byte(frm[i], w);
        finish_req();
        checks++; if (got_req.size() != 2) begin errors++;
            $display("FAIL write_req_count got %0d want 2", got_req.size()); end
        else if (got_req[0] !== e0 || got_req[1] !== e1) begin errors++;
            $display("FAIL write_reqs got %h %h want %h %h", got_req[0], got_req[1], e0, e1); end
        bad = -1;
        if (got_pay.size() == pay.size())
            foreach (pay[i]) if (bad < 0 && got_pay[i] !== pay[i]) bad = i;
        checks++; if (got_pay.size() != pay.size() || bad >= 0) begin errors++;
            $display("FAIL write_payload got n=%0d want n=%0d first_bad=%0d", got_pay.size(),
                     pay.size(), bad); end
    endtask

    task automatic test_crc_err();
        int w;
        int c0;
        logic [43:0] e;
        c0 = n_crc;
        got_req.delete();
        bus.i_mreq_ready = 1'b1;
        make_frame(8'h00, 8'h02, 32'h11223344, 8'h01);
        foreach (frm[i]) send_byte(frm[i], w);
        @(negedge clk);
        checks++; if (bus.o_crc_err !== 1'b1 || bus.o_mreq_valid !== 1'b0) begin errors++;
            $display("FAIL crc_pulse got err=%b valid=%b want 1 0",
                     bus.o_crc_err, bus.o_mreq_valid); end
        checks++; if (bus.o_st_ready !== 1'b1) begin errors++;
            $display("FAIL crc_hunt got rdy=%b want 1", bus.o_st_ready); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.o_crc_err !== 1'b0) begin errors++;
            $display("FAIL crc_single got err=%b want 0", bus.o_crc_err); end
        @(posedge clk); #1;
        checks++; if (got_req.size() != 0 || n_crc != c0 + 1) begin errors++;
            $display("FAIL crc_no_req got req=%0d pulses=%0d want 0 1", got_req.size(),
                     n_crc - c0); end
        e = exp_req(8'h00, 8'h02, 32'h11223344);
        do_frame(8'h00, 8'h02, 32'h11223344, 8'h00);
        checks++; if (got_req.size() != 1 || got_req[0] !== e) begin errors++;
            $display("FAIL crc_recover got n=%0d want 1 req %h", got_req.size(), e); end
    endtask

    task automatic test_garbage();
        int w;
        logic [43:0] e;
        e = exp_req(8'h38, 8'h07, 32'h12A534A5);
        send_byte(8'h00, w);
        send_byte(8'hFF, w);
        send_byte(8'h5A, w);
        do_frame(8'h38, 8'h07, 32'h12A534A5, 8'h00);
        checks++; if (got_req.size() != 1 || got_req[0] !== e) begin errors++;
            $display("FAIL garbage_frame got n=%0d want 1 req %h", got_req.size(), e); end
    endtask

    task automatic test_backpressure();
        int bad;
        bp_en = 1'b1;
        do_frame(8'h01, 8'hFF, 32'h80000000, 8'h00);
        bp_en = 1'b0;
        bad = -1;
        if (got_pay.size() == exp_pay.size())
            foreach (exp_pay[i]) if (bad < 0 && got_pay[i] !== exp_pay[i]) bad = i;
        checks++; if (got_pay.size() != 256 || bad >= 0) begin errors++;
            $display("FAIL bp_payload got n=%0d want 256 first_bad=%0d", got_pay.size(), bad); end
        checks++; if (got_req.size() != 1 || got_req[0] !== exp_req(8'h01, 8'hFF, 32'h80000000))
            begin errors++; $display("FAIL bp_req got n=%0d want 1", got_req.size()); end
    endtask

    task automatic test_random();
        logic [7:0]  op, sz, flip;
        logic [31:0] addr;
        int c0, bad;
        bp_en = 1'b1;
        for (int f = 0; f < 10; f++) begin
            op   = 8'($urandom);
            sz   = 8'($urandom_range(0, 7));
            addr = $urandom;
            flip = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            c0   = n_crc;
            do_frame(op, sz, addr, flip);
            if (flip != 8'h00) begin
                checks++; if (got_req.size() != 0 || n_crc != c0 + 1) begin errors++;
                    $display("FAIL rand_crc frame %0d got req=%0d pulses=%0d want 0 1", f,
                             got_req.size(), n_crc - c0); end
            end else begin
                checks++; if (got_req.size() != 1 || got_req[0] !== exp_req(op, sz, addr)) begin
                    errors++;
                    $display("FAIL rand_req frame %0d got n=%0d want 1 req %h", f,
                             got_req.size(), exp_req(op, sz, addr)); end
                bad = -1;
                if (got_pay.size() == exp_pay.size())
                    foreach (exp_pay[i]) if (bad < 0 && got_pay[i] !== exp_pay[i]) bad = i;
                checks++; if (got_pay.size() != pay_len(op, sz) || bad >= 0) begin errors++;
                    $display("FAIL rand_payload frame %0d got n=%0d want %0d first_bad=%0d", f,
                             got_pay.size(), pay_len(op, sz), bad); end
            end
        end
        bp_en = 1'b0;
        bus.i_mreq_ready    = 1'b0;
        bus.i_rx_data_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int w;
        int c0;
        logic [43:0] e;
        c0 = n_crc;
        bus.i_mreq_ready = 1'b0;
        make_frame(8'h01, 8'h0F, 32'hDEADBEEF, 8'h00);
        foreach (frm[i]) send_byte(frm[i], w);
        for (int i = 0; i < 5; i++) send_byte(8'(i + 1), w);
        bus.i_st_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (bus.o_st_ready !== 1'b1 || bus.o_mreq_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_ctl got rdy=%b valid=%b want 1 0",
                     bus.o_st_ready, bus.o_mreq_valid); end
        checks++; if (w_pack !== 44'h0 || bus.o_rx_data_valid !== 1'b0) begin errors++;
            $display("FAIL rstmid_fields got %h rxv=%b want 0 0", w_pack, bus.o_rx_data_valid); end
        @(posedge clk); #1;
        bus.i_st_valid = 1'b0;
        rst = 1'b0;
        e = exp_req(8'h00, 8'h05, 32'h12345678);
        do_frame(8'h00, 8'h05, 32'h12345678, 8'h00);
        checks++; if (got_req.size() != 1 || got_req[0] !== e || n_crc != c0) begin errors++;
            $display("FAIL rstmid_next got n=%0d crc_pulses=%0d want 1 0", got_req.size(),
                     n_crc - c0); end
    endtask

    task automatic test_timeout();
        int w;
        int hit;
        int t0;
        logic [43:0] e;
        t0  = n_tmo;
        hit = 0;
        e   = exp_req(8'h00, 8'h02, 32'h0BADF00D);
        got_req.delete();
        bus.i_mreq_ready = 1'b0;
        make_frame(8'h00, 8'h02, 32'h0BADF00D, 8'h00);
        for (int i = 0; i < 3; i++) send_byte(frm[i], w);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.o_timeout === 1'b1 && hit == 0) hit = i;
            @(posedge clk); #1;
        end
`ifdef CMD_RX_TIMEOUT_EN
        checks++; if (hit != 17 || n_tmo != t0 + 1) begin errors++;
            $display("FAIL timeout_pulse got cycle=%0d pulses=%0d want 17 1", hit, n_tmo - t0); end
        do_frame(8'h00, 8'h02, 32'h0BADF00D, 8'h00);
`else
        checks++; if (hit != 0 || n_tmo != t0) begin errors++;
            $display("FAIL timeout_none got cycle=%0d pulses=%0d want 0 0", hit, n_tmo - t0); end
        for (int i = 3; i < frm.size(); i++) send_byte(frm[i], w);
        finish_req();
`endif
        checks++; if (got_req.size() != 1 || got_req[0] !== e) begin errors++;
            $display("FAIL timeout_resume got n=%0d want 1 req %h", got_req.size(), e); end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.i_st_data       = 8'h00;
        bus.i_st_valid      = 1'b0;
        bus.i_mreq_ready    = 1'b0;
        bus.i_rx_data_ready = 1'b1;
        test_reset();
        test_read();
        test_write(1'b0);
        test_write(1'b1);
        test_crc_err();
        test_garbage();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
